// File: rtl/multicyc_exec_pkg.sv
// Shared types for the multicycle execute responder: request/response records,
// opcode set, controller states and opcode classification helpers.
package multicyc_exec_pkg;

  typedef enum logic [6:0] {
    OP_NOP   = 7'd0,
    OP_MULT  = 7'd1,
    OP_MULTU = 7'd2,
    OP_MUL   = 7'd3,
    OP_MADD  = 7'd4,
    OP_MADDU = 7'd5,
    OP_MSUB  = 7'd6,
    OP_MSUBU = 7'd7,
    OP_DIV   = 7'd8,
    OP_DIVU  = 7'd9,
    OP_MFHI  = 7'd10,
    OP_MFLO  = 7'd11
  } oper_t;

  typedef struct packed {
    oper_t       op;
    logic        is_multicyc;
    logic [63:0] hilo;
    logic [31:0] reg0;
    logic [31:0] reg1;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [63:0] hilo;
  } multicyc_resp_t;

  typedef enum logic [1:0] {MC_IDLE, MC_MUL, MC_DIV, MC_DONE} multicyc_state_t;

  localparam int unsigned DIV_ITERS   = 32;
  localparam int unsigned DIV_LATENCY = 34;
  localparam int unsigned REQ_W       = $bits(multicyc_req_t);
  localparam int unsigned RESP_W      = $bits(multicyc_resp_t);

  function automatic logic is_mul_op(oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(oper_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(oper_t op);
    return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  endfunction

endpackage

// File: rtl/multicyc_div.sv
// Iterative restoring radix-2 divider: setup on start, 32 iterations on the
// operand magnitudes, then one fixup cycle where done is high and result is valid.
module multicyc_div
  import multicyc_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {DvIdle, DvIter, DvFix} div_state_t;

  localparam logic [4:0] IterLast = 5'(DIV_ITERS - 1);

  div_state_t  st_q, st_d;
  logic [4:0]  iter_q;
  logic [31:0] rem_q, quo_q, dsr_q;
  logic        neg_quo_q, neg_rem_q, dz_q;
  logic        dvd_neg, dsr_neg;
  logic [32:0] trial;

  assign dvd_neg = is_signed & dividend[31];
  assign dsr_neg = is_signed & divisor[31];
  // Borrow out of bit 32 means the shifted remainder was smaller than the divisor.
  assign trial   = {rem_q, quo_q[31]} - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) st_q <= DvIdle;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      DvIdle:  if (start) st_d = DvIter;
      DvIter:  if (iter_q == IterLast) st_d = DvFix;
      DvFix:   st_d = DvIdle;
      default: st_d = DvIdle;
    endcase
    if (abort) st_d = DvIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (start) begin
      iter_q    <= '0;
      rem_q     <= '0;
      quo_q     <= dvd_neg ? -dividend : dividend;
      dsr_q     <= dsr_neg ? -divisor : divisor;
      neg_quo_q <= dvd_neg ^ dsr_neg;
      neg_rem_q <= dvd_neg;
      dz_q      <= (divisor == '0);
    end else if (st_q == DvIter) begin
      iter_q <= iter_q + 5'd1;
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= {rem_q[30:0], quo_q[31]};
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign busy = (st_q != DvIdle);
  assign done = (st_q == DvFix);
  // Divide by zero already leaves rem = |dividend|; sign fixup restores the dividend.
  assign result = {neg_rem_q ? -rem_q : rem_q,
                   dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q)};

endmodule

// File: rtl/multicyc_exec.sv
// Multicycle responder for the EX stage: multiply/accumulate through a short
// register chain, divide through multicyc_div, result returned as a new HI/LO pair.
module multicyc_exec
  import multicyc_exec_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp
);

  localparam logic [2:0] MulLast = 3'(MUL_LATENCY - 1);

  if (MUL_LATENCY < 2 || MUL_LATENCY > 4) begin : g_bad_mul_lat
    $error("MUL_LATENCY must be in 2..4");
  end
  if (DIV_LATENCY != DIV_ITERS + 2) begin : g_bad_div_lat
    $error("DIV_LATENCY must equal setup + iterations + fixup");
  end

  multicyc_req_t   r;
  multicyc_resp_t  o;
  multicyc_state_t state_q, state_d;
  logic [2:0]      cnt_q;
  oper_t           op_q;
  logic [31:0]     a_q, b_q;
  logic [63:0]     acc_q, result_q;
  logic            accept, div_start, passthru, mul_last;
  logic            div_busy, div_done;
  logic [63:0]     div_result;
  logic [63:0]     a64, b64, prod, mul_result;

  assign r         = multicyc_req_t'(req);
  assign resp      = o;
  assign accept    = (state_q == MC_IDLE) && r.is_multicyc && !flush;
  assign div_start = accept && is_div_op(r.op);
  assign passthru  = accept && !is_mul_op(r.op) && !is_div_op(r.op);
  assign mul_last  = (state_q == MC_MUL) && (cnt_q == MulLast);

  always_ff @(posedge clk) begin
    if (rst) state_q <= MC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: begin
        if (accept) begin
          if (is_mul_op(r.op))      state_d = MC_MUL;
          else if (is_div_op(r.op)) state_d = MC_DIV;
          else                      state_d = MC_DONE;
        end
      end
      MC_MUL:  if (mul_last) state_d = MC_DONE;
      MC_DIV:  if (div_done) state_d = MC_DONE;
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
    if (flush) state_d = MC_IDLE;
  end

  // Operands are latched at accept; the product settles over the MUL cycles.
  assign a64  = is_signed_op(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b64  = is_signed_op(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod = a64 * b64;

  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_result = acc_q + prod;
      OP_MSUB, OP_MSUBU: mul_result = acc_q - prod;
      default:           mul_result = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= 3'd1;
        op_q  <= r.op;
        a_q   <= r.reg0;
        b_q   <= r.reg1;
        acc_q <= r.hilo;
      end else if (state_q == MC_MUL) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (!flush) begin
        if (passthru)      result_q <= r.hilo;
        else if (mul_last) result_q <= mul_result;
        else if (div_done) result_q <= div_result;
      end
    end
  end

  multicyc_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (r.reg0),
    .divisor   (r.reg1),
    .is_signed (is_signed_op(r.op)),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  always_comb begin
    o.ready = 1'b0;
    o.valid = 1'b0;
    o.hilo  = result_q;
    if (rst) begin
      o.hilo = '0;
    end else if (state_q == MC_IDLE && !r.is_multicyc) begin
      o.ready = 1'b1;
      o.valid = 1'b1;
      o.hilo  = r.hilo;
    end else if (state_q == MC_DONE && !flush) begin
      o.ready = 1'b1;
      o.valid = 1'b1;
    end
  end

  a_div_busy: assert property (@(posedge clk) disable iff (rst) (state_q == MC_DIV) |-> div_busy);

endmodule

// File: tb/tb_multicyc_exec.sv
// Self-checking bench for multicyc_exec: directed vector table, hand-written
// flush/reset sequences and random operations against an arithmetic model.
module tb_multicyc_exec;
  import multicyc_exec_pkg::*;

  localparam int MUL_LAT = 3;

  typedef struct {
    oper_t       op;
    logic        mc;
    logic [63:0] hl;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [REQ_W-1:0]  req;
  logic [RESP_W-1:0] resp;
  multicyc_resp_t    rs;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] last_res = '0;
  vec_t        vecs[14];
  oper_t       ops_l[11];

  assign rs = multicyc_resp_t'(resp);

  multicyc_exec #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .req   (req),
    .resp  (resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(oper_t op, logic [63:0] hl, logic [31:0] a,
                                        logic [31:0] b);
    longint sa, sb, ua, ub, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      OP_MULT, OP_MUL: return sa * sb;
      OP_MULTU:        return ua * ub;
      OP_MADD:         return hl + sa * sb;
      OP_MADDU:        return hl + ua * ub;
      OP_MSUB:         return hl - sa * sb;
      OP_MSUBU:        return hl - ua * ub;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q  = (op == OP_DIV) ? sa / sb : ua / ub;
        rm = (op == OP_DIV) ? sa % sb : ua % ub;
        return {rm[31:0], q[31:0]};
      end
      default:         return hl;
    endcase
  endfunction

  function automatic int model_lat(oper_t op, logic mc);
    if (!mc) return 0;
    if (op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU})
      return MUL_LAT;
    if (op inside {OP_DIV, OP_DIVU}) return 34;
    return 1;
  endfunction

  task automatic drive(input oper_t op, input logic mc, input logic [63:0] hl,
                       input logic [31:0] a, input logic [31:0] b);
    multicyc_req_t rq;
    rq.op          = op;
    rq.is_multicyc = mc;
    rq.hilo        = hl;
    rq.reg0        = a;
    rq.reg1        = b;
    req            = rq;
  endtask

  // Called just after a posedge; the request is presented in cycle 0.
  task automatic do_op(input string name, input oper_t op, input logic mc,
                       input logic [63:0] hl, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat);
    int   cyc;
    logic hold_ok;
    drive(op, mc, hl, a, b);
    cyc     = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    while (!rs.ready && cyc < 100) begin
      if (rs.valid !== 1'b0 || rs.hilo !== last_res) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(lat));
    chk({name, " hilo"}, rs.hilo, exp);
    chk({name, " busy/valid"}, {63'd0, hold_ok & (rs.valid === rs.ready)}, 64'd1);
    if (mc) last_res = exp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{OP_NOP,   1'b0, 64'h0123_4567_89AB_CDEF, 32'h0, 32'h0,
                 64'h0123_4567_89AB_CDEF, 0};
    vecs[1]  = '{OP_MULT,  1'b1, 64'h0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 3};
    vecs[2]  = '{OP_MADDU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd1, 64'h0, 3};
    vecs[3]  = '{OP_MSUB,  1'b1, 64'h0, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 3};
    vecs[4]  = '{OP_DIV,   1'b1, 64'h0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[5]  = '{OP_DIVU,  1'b1, 64'h0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34};
    vecs[6]  = '{OP_DIVU,  1'b1, 64'h0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 34};
    vecs[7]  = '{OP_DIV,   1'b1, 64'h0, 32'h8000_0000, 32'hFFFF_FFFF,
                 64'h0000_0000_8000_0000, 34};
    vecs[8]  = '{OP_MFHI,  1'b1, 64'hDEAD_BEEF_0BAD_F00D, 32'h0, 32'h0,
                 64'hDEAD_BEEF_0BAD_F00D, 1};
    vecs[9]  = '{OP_MULTU, 1'b1, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'hFFFF_FFFE_0000_0001, 3};
    vecs[10] = '{OP_MUL,   1'b1, 64'd55, 32'd7, 32'd6, 64'd42, 3};
    vecs[11] = '{OP_DIV,   1'b1, 64'h0, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 34};
    vecs[12] = '{OP_MADD,  1'b1, 64'd10, 32'hFFFF_FFFE, 32'd3, 64'd4, 3};
    vecs[13] = '{OP_DIV,   1'b1, 64'h0, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34};
    ops_l = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
              OP_DIV, OP_DIVU, OP_MFHI, OP_NOP};

    rst   = 1'b1;
    flush = 1'b0;
    drive(OP_NOP, 1'b0, 64'h5555_AAAA_5555_AAAA, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset resp", {62'd0, rs.ready, rs.valid} | 64'(rs.hilo != 64'd0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table, issued back to back.
    for (int i = 0; i < 14; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].mc, vecs[i].hl, vecs[i].a,
            vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush a divide at cycle 10; a MULT issued the next cycle must run normally.
    begin
      logic saw;
      saw = 1'b0;
      drive(OP_DIV, 1'b1, 64'h0, 32'd1000, 32'd3);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (rs.ready || rs.valid) saw = 1'b1;
        @(posedge clk);
        #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush no pulse", {63'd0, saw | rs.ready | rs.valid}, 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      do_op("after flush", OP_MULT, 1'b1, 64'h0, 32'd123, 32'hFFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FF85, 3);
    end

    // Flush in IDLE with a multicycle request: not accepted that cycle.
    drive(OP_MULTU, 1'b1, 64'h0, 32'd9, 32'd9);
    flush = 1'b1;
    @(negedge clk);
    chk("idle flush ready", {63'd0, rs.ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_op("idle flush then op", OP_MULTU, 1'b1, 64'h0, 32'd9, 32'd9, 64'd81, 3);

    // Reset in the middle of a multiply.
    drive(OP_MULT, 1'b1, 64'h0, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid-mul reset resp", {62'd0, rs.ready, rs.valid} | 64'(rs.hilo != 64'd0), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_res = '0;
    do_op("post-reset passthru", OP_MFLO, 1'b1, 64'h0000_0000_0000_BEEF, 32'h0, 32'h0,
          64'h0000_0000_0000_BEEF, 1);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      oper_t       op;
      logic        mc;
      logic [31:0] a, b;
      logic [63:0] hl;
      int          sel;
      op  = ops_l[$urandom_range(0, 10)];
      mc  = ($urandom_range(0, 7) != 0);
      a   = $urandom;
      b   = $urandom;
      hl  = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      do_op($sformatf("rand%0d", i), op, mc, hl, a, b, mc ? model(op, hl, a, b) : hl,
            model_lat(op, mc));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
